// File: rtl/ipu_input_unit_if.sv
// ============================================================================
// Module   : ipu_input_unit_if
// Brief    : Button, cursor and interrupt-handshake bundle between the board,
//            the input processing unit and the processor core.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface ipu_input_unit_if;
    logic       btn_next;
    logic       btn_prev;
    logic       btn_sel;
    logic       int_ack;
    logic       ipu_int;
    logic [3:0] grid_coord;
    logic [3:0] cursor;

    // Board/core side: drives the raw buttons and the acknowledge.
    modport master (
        output btn_next, btn_prev, btn_sel, int_ack,
        input  ipu_int, grid_coord, cursor
    );

    // Input unit side.
    modport slave (
        input  btn_next, btn_prev, btn_sel, int_ack,
        output ipu_int, grid_coord, cursor
    );
endinterface

`default_nettype wire

// File: rtl/ipu_input_unit.sv
// ============================================================================
// Module   : ipu_input_unit
// Brief    : Debounces three pushbuttons, moves a 3x3 cursor and raises an
//            interrupt with the selected cell until the core acknowledges.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module ipu_input_unit #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20
) (
    input  wire logic          clk,
    input  wire logic          rst,
    ipu_input_unit_if.slave    bus
);

    localparam logic [CNT_W-1:0] c_cnt_max  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       c_cell_max = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PEND    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    // Bit order: 0 = next, 1 = prev, 2 = sel.
    logic [2:0] w_raw;
    logic [2:0] w_press;

    assign w_raw = {bus.btn_sel, bus.btn_prev, bus.btn_next};

    generate
        for (genvar g = 0; g < 3; g++) begin : g_btn
            logic             r_s1;
            logic             r_s2;
            logic             r_stable;
            logic             r_press;
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk) begin
                if (!rst) begin
                    r_s1     <= 1'b1;
                    r_s2     <= 1'b1;
                    r_stable <= 1'b1;
                    r_press  <= 1'b0;
                    r_cnt    <= '0;
                end else begin
                    r_s1    <= w_raw[g];
                    r_s2    <= r_s1;
                    r_press <= 1'b0;
                    if (r_s2 == r_stable) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        // Level accepted; a 1->0 flip is a press, 0->1 is silent.
                        r_stable <= r_s2;
                        r_cnt    <= '0;
                        r_press  <= r_stable;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            assign w_press[g] = r_press;
        end
    endgenerate

    logic       w_next;
    logic       w_prev;
    logic       w_sel;
    logic [3:0] r_cursor;
    logic [3:0] w_cursor_nxt;
    logic [3:0] r_coord;
    state_t     r_state;
    state_t     w_state_nxt;
    logic       w_load_coord;

    assign w_next = w_press[0];
    assign w_prev = w_press[1];
    assign w_sel  = w_press[2];

    always_comb begin
        w_cursor_nxt = r_cursor;
        if (w_next && !w_prev) begin
            w_cursor_nxt = (r_cursor == c_cell_max) ? 4'd0 : r_cursor + 4'd1;
        end else if (w_prev && !w_next) begin
            w_cursor_nxt = (r_cursor == 4'd0) ? c_cell_max : r_cursor - 4'd1;
        end
    end

    // RELEASE waits for ack to drop so a held ack cannot re-trigger.
    always_comb begin
        w_state_nxt  = r_state;
        w_load_coord = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel) begin
                    w_state_nxt  = ST_PEND;
                    w_load_coord = 1'b1;
                end
            end
            ST_PEND: begin
                if (bus.int_ack) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (!bus.int_ack) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= ST_IDLE;
            r_cursor <= 4'd0;
            r_coord  <= 4'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_cursor <= w_cursor_nxt;
            // Captures the pre-move cursor when sel and a move coincide.
            if (w_load_coord) begin
                r_coord <= r_cursor;
            end
        end
    end

    assign bus.ipu_int    = (r_state == ST_PEND);
    assign bus.grid_coord = r_coord;
    assign bus.cursor     = r_cursor;

endmodule

`default_nettype wire

// File: tb/tb_ipu_input_unit.sv
// ============================================================================
// Module   : tb_ipu_input_unit
// Brief    : Directed bench for ipu_input_unit with cursor/coordinate scoreboard.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ipu_input_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;

    always #5 clk = ~clk;

    ipu_input_unit_if bus ();

    ipu_input_unit #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         n_cmp = 0;
    int         n_err = 0;
    int         cyc = 0;
    int         last_move_cyc = 0;
    int         c0;
    bit         mon_en = 1'b0;
    logic [3:0] prev_cursor;
    logic       prev_int;
    logic [3:0] q_cursor [$];
    logic [3:0] q_coord [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // One cycle; sampled on the falling edge, scoreboard popped on each output event.
    task automatic step();
        @(negedge clk);
        cyc++;
        if (mon_en) begin
            if (bus.cursor !== prev_cursor) begin
                last_move_cyc = cyc;
                if (q_cursor.size() == 0)
                    check("cursor_unexpected_move", {28'd0, bus.cursor}, {28'd0, prev_cursor});
                else
                    check("cursor", {28'd0, bus.cursor}, {28'd0, q_cursor.pop_front()});
            end
            if (bus.ipu_int === 1'b1 && prev_int !== 1'b1) begin
                if (q_coord.size() == 0)
                    check("ipu_int_unexpected_rise", {31'd0, bus.ipu_int}, {31'd0, prev_int});
                else
                    check("grid_coord_on_int", {28'd0, bus.grid_coord}, {28'd0, q_coord.pop_front()});
            end
            prev_cursor = bus.cursor;
            prev_int    = bus.ipu_int;
        end
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic press(input bit nx, input bit pv, input bit sl, input int low_n, input int high_n);
        if (nx) bus.btn_next = 1'b0;
        if (pv) bus.btn_prev = 1'b0;
        if (sl) bus.btn_sel  = 1'b0;
        steps(low_n);
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        bus.btn_sel  = 1'b1;
        steps(high_n);
    endtask

    task automatic ack_handshake();
        bus.int_ack = 1'b1;
        steps(2);
        bus.int_ack = 1'b0;
        steps(2);
    endtask

    initial begin
        bus.btn_next = 1'b1;
        bus.btn_prev = 1'b1;
        bus.btn_sel  = 1'b1;
        bus.int_ack  = 1'b0;

        // Reset values
        rst = 1'b0;
        steps(3);
        check("reset_ipu_int", {31'd0, bus.ipu_int}, 32'd0);
        check("reset_grid_coord", {28'd0, bus.grid_coord}, 32'd0);
        check("reset_cursor", {28'd0, bus.cursor}, 32'd0);
        rst = 1'b1;
        prev_cursor = bus.cursor;
        prev_int    = bus.ipu_int;
        mon_en      = 1'b1;

        // Next presses walk 1..8, wrap to 0, then 1; land 6 edges after first sample
        for (int i = 1; i <= 10; i++) begin
            q_cursor.push_back(4'(i % 9));
            c0 = cyc;
            press(1'b1, 1'b0, 1'b0, 8, 8);
            check("next_latency", 32'(last_move_cyc - c0 - 1), 32'd6);
        end

        // Bouncy prev: only the final long low counts (1 -> 0)
        q_cursor.push_back(4'd0);
        for (int i = 0; i < 5; i++) begin
            bus.btn_prev = 1'b0;
            steps(3);
            bus.btn_prev = 1'b1;
            steps(1);
        end
        press(1'b0, 1'b1, 1'b0, 10, 10);
        check("bounce_cursor", {28'd0, bus.cursor}, 32'd0);

        // Clean prev wraps 0 -> 8
        q_cursor.push_back(4'd8);
        press(1'b0, 1'b1, 1'b0, 8, 8);

        // Walk to 5: 0,1,2,3,4,5
        for (int i = 0; i <= 5; i++) begin
            q_cursor.push_back(4'(i));
            press(1'b1, 1'b0, 1'b0, 8, 8);
        end

        // Select handshake
        q_coord.push_back(4'd5);
        press(1'b0, 1'b0, 1'b1, 8, 8);
        check("sel_ipu_int", {31'd0, bus.ipu_int}, 32'd1);
        check("sel_grid_coord", {28'd0, bus.grid_coord}, 32'd5);
        press(1'b0, 1'b0, 1'b1, 8, 8);
        check("pend_second_sel_int", {31'd0, bus.ipu_int}, 32'd1);
        check("pend_second_sel_coord", {28'd0, bus.grid_coord}, 32'd5);
        bus.int_ack = 1'b1;
        step();
        check("ack_falls_one_edge", {31'd0, bus.ipu_int}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("ack_held_no_retrigger", {31'd0, bus.ipu_int}, 32'd0);
        end
        bus.int_ack = 1'b0;
        steps(2);
        q_coord.push_back(4'd5);
        press(1'b0, 1'b0, 1'b1, 8, 8);
        check("reselect_ipu_int", {31'd0, bus.ipu_int}, 32'd1);
        ack_handshake();

        // Simultaneous sel + next at cursor 3
        q_cursor.push_back(4'd4);
        press(1'b0, 1'b1, 1'b0, 8, 8);
        q_cursor.push_back(4'd3);
        press(1'b0, 1'b1, 1'b0, 8, 8);
        q_coord.push_back(4'd3);
        q_cursor.push_back(4'd4);
        press(1'b1, 1'b0, 1'b1, 8, 8);
        check("simul_grid_coord", {28'd0, bus.grid_coord}, 32'd3);
        check("simul_cursor", {28'd0, bus.cursor}, 32'd4);
        ack_handshake();
        press(1'b1, 1'b1, 1'b0, 8, 8);
        check("next_prev_cancel", {28'd0, bus.cursor}, 32'd4);

        // Reset while pending with grid_coord 7
        for (int i = 5; i <= 7; i++) begin
            q_cursor.push_back(4'(i));
            press(1'b1, 1'b0, 1'b0, 8, 8);
        end
        q_coord.push_back(4'd7);
        press(1'b0, 1'b0, 1'b1, 8, 8);
        check("pend7_grid_coord", {28'd0, bus.grid_coord}, 32'd7);
        q_cursor.push_back(4'd0);
        rst = 1'b0;
        step();
        check("midrst_ipu_int", {31'd0, bus.ipu_int}, 32'd0);
        check("midrst_grid_coord", {28'd0, bus.grid_coord}, 32'd0);
        check("midrst_cursor", {28'd0, bus.cursor}, 32'd0);
        rst = 1'b1;
        step();
        q_coord.push_back(4'd0);
        press(1'b0, 1'b0, 1'b1, 8, 8);
        check("post_rst_idle_sel", {31'd0, bus.ipu_int}, 32'd1);

        check("cursor_queue_drained", 32'(q_cursor.size()), 32'd0);
        check("coord_queue_drained", 32'(q_coord.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
